// File: rtl/eprom_array_model.sv
// Synthesizable stand-in for the 4-byte OTP EPROM macro: one-way cell bits, weak-program
// tracking for margin reads, program-pulse timing checks and sticky protocol error flags.
`timescale 1ns/1ps
module eprom_array_model #(
    parameter int PGM_MIN_CYC  = 1000,
    parameter int PGM_FULL_CYC = 1100,
    parameter int READ_LAT     = 1,
    parameter int CNT_W        = 13
) (
    input  logic       clk_div,
    input  logic       rst_n,
    input  logic       xce,
    input  logic       xread,
    input  logic       xpgm,
    input  logic       xtm,
    input  logic [1:0] xa,
    input  logic [7:0] xdin,
    input  logic       vpp_en,
    input  logic       err_clr,
    output logic [7:0] dq,
    output logic       rd_valid,
    output logic       pgm_busy,
    output logic [7:0] pgm_count,
    output logic       err_short,
    output logic       err_vpp,
    output logic       err_unstable,
    output logic       err_conflict
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ACC   = 3'd1;
    localparam logic [2:0] S_RD_VALID = 3'd2;
    localparam logic [2:0] S_PGM      = 3'd3;
    localparam logic [2:0] S_ABORT    = 3'd4;

    localparam logic [CNT_W-1:0] PW_MIN  = CNT_W'(PGM_MIN_CYC);
    localparam logic [CNT_W-1:0] PW_FULL = CNT_W'(PGM_FULL_CYC);
    localparam logic [3:0]       RD_LAT  = 4'(READ_LAT);

    logic [2:0]       state_q, state_d;
    logic [7:0]       cell_q [4];
    logic [7:0]       cell_d [4];
    logic [7:0]       weak_q [4];
    logic [7:0]       weak_d [4];
    logic [7:0]       dq_q, dq_d;
    logic             rd_valid_q, rd_valid_d;
    logic             pgm_busy_q, pgm_busy_d;
    logic [7:0]       pgm_count_q, pgm_count_d;
    logic             err_short_q, err_short_d;
    logic             err_vpp_q, err_vpp_d;
    logic             err_unstable_q, err_unstable_d;
    logic             err_conflict_q, err_conflict_d;
    logic [CNT_W-1:0] pw_q, pw_d;
    logic [3:0]       rc_q, rc_d;
    logic [1:0]       lat_xa_q, lat_xa_d;
    logic [7:0]       lat_xdin_q, lat_xdin_d;

    logic       set_short, set_vpp, set_unstable;
    logic       conflict;
    logic [7:0] rd_data;

    assign conflict = xread & xpgm;
    assign rd_data  = xtm ? (cell_q[xa] | weak_q[xa]) : cell_q[xa];

    always_comb begin
        state_d      = state_q;
        cell_d       = cell_q;
        weak_d       = weak_q;
        dq_d         = dq_q;
        rd_valid_d   = rd_valid_q;
        pgm_busy_d   = pgm_busy_q;
        pgm_count_d  = pgm_count_q;
        pw_d         = pw_q;
        rc_d         = rc_q;
        lat_xa_d     = lat_xa_q;
        lat_xdin_d   = lat_xdin_q;
        set_short    = 1'b0;
        set_vpp      = 1'b0;
        set_unstable = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xce && xpgm) begin
                    if (vpp_en) begin
                        state_d    = S_PGM;
                        lat_xa_d   = xa;
                        lat_xdin_d = xdin;
                        pw_d       = CNT_W'(1);
                        pgm_busy_d = 1'b1;
                    end else begin
                        state_d = S_ABORT;
                        set_vpp = 1'b1;
                    end
                end else if (xce && xread) begin
                    lat_xa_d = xa;
                    rc_d     = 4'd1;
                    if (RD_LAT <= 4'd1) begin
                        state_d    = S_RD_VALID;
                        dq_d       = rd_data;
                        rd_valid_d = 1'b1;
                    end else begin
                        state_d = S_RD_ACC;
                    end
                end
            end
            S_RD_ACC: begin
                if (conflict || !(xce && xread)) begin
                    state_d    = S_IDLE;
                    dq_d       = 8'h00;
                    rd_valid_d = 1'b0;
                end else if (xa != lat_xa_q) begin
                    lat_xa_d = xa;
                    rc_d     = 4'd1;
                end else if ((rc_q + 4'd1) >= RD_LAT) begin
                    state_d    = S_RD_VALID;
                    dq_d       = rd_data;
                    rd_valid_d = 1'b1;
                end else begin
                    rc_d = rc_q + 4'd1;
                end
            end
            S_RD_VALID: begin
                if (conflict || !(xce && xread)) begin
                    state_d    = S_IDLE;
                    dq_d       = 8'h00;
                    rd_valid_d = 1'b0;
                end else if (xa != lat_xa_q) begin
                    state_d    = S_RD_ACC;
                    lat_xa_d   = xa;
                    rc_d       = 4'd1;
                    dq_d       = 8'h00;
                    rd_valid_d = 1'b0;
                end
            end
            S_PGM: begin
                // Supply and signal-stability violations win over a trailing edge in the same cycle.
                if (!vpp_en) begin
                    set_vpp    = 1'b1;
                    state_d    = S_ABORT;
                    pgm_busy_d = 1'b0;
                end else if (!xce || (xa != lat_xa_q) || (xdin != lat_xdin_q)) begin
                    set_unstable = 1'b1;
                    state_d      = S_ABORT;
                    pgm_busy_d   = 1'b0;
                end else if (xpgm) begin
                    if (pw_q != {CNT_W{1'b1}}) pw_d = pw_q + CNT_W'(1);
                end else begin
                    state_d    = S_IDLE;
                    pgm_busy_d = 1'b0;
                    if (pw_q < PW_MIN) begin
                        set_short = 1'b1;
                    end else begin
                        cell_d[lat_xa_q] = cell_q[lat_xa_q] & lat_xdin_q;
                        if (pw_q < PW_FULL) weak_d[lat_xa_q] = weak_q[lat_xa_q] | ~lat_xdin_q;
                        else                weak_d[lat_xa_q] = weak_q[lat_xa_q] & lat_xdin_q;
                        if (pgm_count_q != 8'hFF) pgm_count_d = pgm_count_q + 8'd1;
                    end
                end
            end
            S_ABORT: begin
                pgm_busy_d = 1'b0;
                if (!xpgm) state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                pgm_busy_d = 1'b0;
            end
        endcase

        err_short_d    = err_clr ? 1'b0 : (err_short_q    | set_short);
        err_vpp_d      = err_clr ? 1'b0 : (err_vpp_q      | set_vpp);
        err_unstable_d = err_clr ? 1'b0 : (err_unstable_q | set_unstable);
        err_conflict_d = err_clr ? 1'b0 : (err_conflict_q | conflict);
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                cell_q[i] <= 8'hFF;
                weak_q[i] <= 8'h00;
            end
            dq_q           <= 8'h00;
            rd_valid_q     <= 1'b0;
            pgm_busy_q     <= 1'b0;
            pgm_count_q    <= 8'h00;
            err_short_q    <= 1'b0;
            err_vpp_q      <= 1'b0;
            err_unstable_q <= 1'b0;
            err_conflict_q <= 1'b0;
            pw_q           <= '0;
            rc_q           <= 4'd0;
            lat_xa_q       <= 2'd0;
            lat_xdin_q     <= 8'hFF;
        end else begin
            state_q        <= state_d;
            cell_q         <= cell_d;
            weak_q         <= weak_d;
            dq_q           <= dq_d;
            rd_valid_q     <= rd_valid_d;
            pgm_busy_q     <= pgm_busy_d;
            pgm_count_q    <= pgm_count_d;
            err_short_q    <= err_short_d;
            err_vpp_q      <= err_vpp_d;
            err_unstable_q <= err_unstable_d;
            err_conflict_q <= err_conflict_d;
            pw_q           <= pw_d;
            rc_q           <= rc_d;
            lat_xa_q       <= lat_xa_d;
            lat_xdin_q     <= lat_xdin_d;
        end
    end

    assign dq           = dq_q;
    assign rd_valid     = rd_valid_q;
    assign pgm_busy     = pgm_busy_q;
    assign pgm_count    = pgm_count_q;
    assign err_short    = err_short_q;
    assign err_vpp      = err_vpp_q;
    assign err_unstable = err_unstable_q;
    assign err_conflict = err_conflict_q;

endmodule

// File: tb/tb_eprom_array_model.sv
// Directed bench for eprom_array_model: read data is scoreboarded through a queue, flags and
// counters are checked with immediate assertions after each step.
`timescale 1ns/1ps
module tb_eprom_array_model;

    localparam int READ_LAT = 1;

    logic       clk_div = 1'b0;
    logic       rst_n;
    logic       xce, xread, xpgm, xtm, vpp_en, err_clr;
    logic [1:0] xa;
    logic [7:0] xdin;
    logic [7:0] dq;
    logic       rd_valid, pgm_busy;
    logic [7:0] pgm_count;
    logic       err_short, err_vpp, err_unstable, err_conflict;
    logic [3:0] errs;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb_q[$];

    eprom_array_model #(
        .PGM_MIN_CYC (1000),
        .PGM_FULL_CYC(1100),
        .READ_LAT    (READ_LAT),
        .CNT_W       (13)
    ) dut (
        .clk_div     (clk_div),
        .rst_n       (rst_n),
        .xce         (xce),
        .xread       (xread),
        .xpgm        (xpgm),
        .xtm         (xtm),
        .xa          (xa),
        .xdin        (xdin),
        .vpp_en      (vpp_en),
        .err_clr     (err_clr),
        .dq          (dq),
        .rd_valid    (rd_valid),
        .pgm_busy    (pgm_busy),
        .pgm_count   (pgm_count),
        .err_short   (err_short),
        .err_vpp     (err_vpp),
        .err_unstable(err_unstable),
        .err_conflict(err_conflict)
    );

    assign errs = {err_conflict, err_unstable, err_vpp, err_short};

    always #5 clk_div = ~clk_div;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One read transaction from IDLE: expected byte goes into the scoreboard, is popped once
    // rd_valid appears (or the wait budget runs out) and compared along with the latency.
    task automatic applyStimulus(input logic [1:0] addr, input logic tm, input logic [7:0] expected,
                                 input string tag);
        int         cycles;
        logic [7:0] exp_dq;
        sb_q.push_back(expected);
        @(negedge clk_div);
        xce = 1'b1; xread = 1'b1; xa = addr; xtm = tm;
        cycles = 0;
        do begin
            @(negedge clk_div);
            cycles++;
        end while (!rd_valid && cycles < 20);
        exp_dq = sb_q.pop_front();
        checkOutput({tag, "_lat"}, 32'(cycles), 32'(READ_LAT));
        checkOutput(tag, {24'h0, dq}, {24'h0, exp_dq});
        xread = 1'b0; xtm = 1'b0;
        @(negedge clk_div);
    endtask

    task automatic programPulse(input logic [1:0] addr, input logic [7:0] data, input int width);
        @(negedge clk_div);
        xce = 1'b1; xa = addr; xdin = data; vpp_en = 1'b1; xpgm = 1'b1;
        repeat (width) @(posedge clk_div);
        @(negedge clk_div);
        xpgm = 1'b0;
        @(negedge clk_div);
    endtask

    task automatic clearErrors();
        @(negedge clk_div);
        err_clr = 1'b1;
        @(negedge clk_div);
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; xce = 1'b0; xread = 1'b0; xpgm = 1'b0; xtm = 1'b0;
        vpp_en = 1'b0; err_clr = 1'b0; xa = 2'd0; xdin = 8'hFF;
        repeat (3) @(negedge clk_div);
        checkOutput("rst_dq", {24'h0, dq}, 32'h0);
        checkOutput("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        checkOutput("rst_busy", {31'h0, pgm_busy}, 32'h0);
        checkOutput("rst_count", {24'h0, pgm_count}, 32'h0);
        checkOutput("rst_errs", {28'h0, errs}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk_div);

        $display("[TB] erased reads");
        for (int a = 0; a < 4; a++) applyStimulus(2'(a), 1'b0, 8'hFF, $sformatf("erased_rd%0d", a));
        checkOutput("dq_idle", {24'h0, dq}, 32'h0);

        $display("[TB] strong program 5A at xa=2");
        programPulse(2'd2, 8'h5A, 1100);
        checkOutput("cnt_after_5a", {24'h0, pgm_count}, 32'd1);
        checkOutput("errs_after_5a", {28'h0, errs}, 32'h0);
        applyStimulus(2'd2, 1'b0, 8'h5A, "rd_5a");
        applyStimulus(2'd2, 1'b1, 8'h5A, "margin_5a");

        $display("[TB] weak program then strengthen at xa=1");
        programPulse(2'd1, 8'h0F, 1020);
        checkOutput("cnt_after_weak", {24'h0, pgm_count}, 32'd2);
        applyStimulus(2'd1, 1'b0, 8'h0F, "rd_weak");
        applyStimulus(2'd1, 1'b1, 8'hFF, "margin_weak");
        programPulse(2'd1, 8'h0F, 1100);
        checkOutput("cnt_after_strong", {24'h0, pgm_count}, 32'd3);
        applyStimulus(2'd1, 1'b1, 8'h0F, "margin_strong");

        $display("[TB] short pulse");
        programPulse(2'd3, 8'h00, 900);
        checkOutput("errs_short", {28'h0, errs}, 32'b0001);
        checkOutput("cnt_short", {24'h0, pgm_count}, 32'd3);
        applyStimulus(2'd3, 1'b0, 8'hFF, "rd_short");
        clearErrors();
        checkOutput("errs_cleared", {28'h0, errs}, 32'h0);

        $display("[TB] program without supply");
        @(negedge clk_div);
        xce = 1'b1; xa = 2'd0; xdin = 8'h00; vpp_en = 1'b0; xpgm = 1'b1;
        repeat (5) @(negedge clk_div);
        checkOutput("errs_novpp", {28'h0, errs}, 32'b0010);
        checkOutput("busy_novpp", {31'h0, pgm_busy}, 32'h0);
        xpgm = 1'b0;
        @(negedge clk_div);
        checkOutput("cnt_novpp", {24'h0, pgm_count}, 32'd3);
        applyStimulus(2'd0, 1'b0, 8'hFF, "rd_novpp");
        clearErrors();

        $display("[TB] supply lost mid-pulse");
        @(negedge clk_div);
        xce = 1'b1; xa = 2'd0; xdin = 8'h00; vpp_en = 1'b1; xpgm = 1'b1;
        repeat (200) @(negedge clk_div);
        checkOutput("busy_mid_pulse", {31'h0, pgm_busy}, 32'h1);
        vpp_en = 1'b0;
        @(negedge clk_div);
        checkOutput("errs_vpp_drop", {28'h0, errs}, 32'b0010);
        checkOutput("busy_vpp_drop", {31'h0, pgm_busy}, 32'h0);
        vpp_en = 1'b1;
        repeat (10) @(negedge clk_div);
        checkOutput("busy_held_abort", {31'h0, pgm_busy}, 32'h0);
        xpgm = 1'b0;
        repeat (2) @(negedge clk_div);
        checkOutput("cnt_vpp_drop", {24'h0, pgm_count}, 32'd3);
        applyStimulus(2'd0, 1'b0, 8'hFF, "rd_vpp_drop");
        clearErrors();

        $display("[TB] address change mid-pulse");
        @(negedge clk_div);
        xce = 1'b1; xa = 2'd0; xdin = 8'h00; vpp_en = 1'b1; xpgm = 1'b1;
        repeat (499) @(negedge clk_div);
        xa = 2'd1;
        @(negedge clk_div);
        checkOutput("errs_unstable", {28'h0, errs}, 32'b0100);
        checkOutput("busy_unstable", {31'h0, pgm_busy}, 32'h0);
        xpgm = 1'b0;
        @(negedge clk_div);
        checkOutput("cnt_unstable", {24'h0, pgm_count}, 32'd3);
        applyStimulus(2'd0, 1'b0, 8'hFF, "rd_unstable0");
        applyStimulus(2'd1, 1'b0, 8'h0F, "rd_unstable1");
        clearErrors();

        $display("[TB] read/program conflict");
        @(negedge clk_div);
        xce = 1'b1; xread = 1'b1; xa = 2'd2; xtm = 1'b0; vpp_en = 1'b0;
        @(negedge clk_div);
        checkOutput("conf_rd_valid", {31'h0, rd_valid}, 32'h1);
        checkOutput("conf_rd_dq", {24'h0, dq}, 32'h5A);
        xpgm = 1'b1;
        @(negedge clk_div);
        checkOutput("conf_dq", {24'h0, dq}, 32'h0);
        checkOutput("conf_rd_valid_lo", {31'h0, rd_valid}, 32'h0);
        checkOutput("conf_errs1", {28'h0, errs}, 32'b1000);
        @(negedge clk_div);
        checkOutput("conf_errs2", {28'h0, errs}, 32'b1010);
        xpgm = 1'b0; xread = 1'b0; vpp_en = 1'b1;
        repeat (2) @(negedge clk_div);
        clearErrors();
        checkOutput("conf_cleared", {28'h0, errs}, 32'h0);

        $display("[TB] reset mid-pulse");
        @(negedge clk_div);
        xce = 1'b1; xa = 2'd2; xdin = 8'h00; vpp_en = 1'b1; xpgm = 1'b1;
        repeat (300) @(negedge clk_div);
        checkOutput("busy_before_rst", {31'h0, pgm_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'h0, pgm_busy}, 32'h0);
        checkOutput("midrst_count", {24'h0, pgm_count}, 32'h0);
        checkOutput("midrst_errs", {28'h0, errs}, 32'h0);
        checkOutput("midrst_dq", {24'h0, dq}, 32'h0);
        xpgm = 1'b0;
        @(negedge clk_div);
        rst_n = 1'b1;
        applyStimulus(2'd2, 1'b0, 8'hFF, "rd_after_rst2");
        applyStimulus(2'd1, 1'b0, 8'hFF, "rd_after_rst1");
        applyStimulus(2'd1, 1'b1, 8'hFF, "margin_after_rst1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
